axi_mem_arbiter: RTL and testbench

Two-port arbiter that shares the core's single AXI memory master between the instruction-fetch unit (read-only) and the LSU (read and write). It sits between IFU/LSU and the top-level AXI interface. It serialises traffic to one outstanding transaction at a time, grants round-robin between the two requesters, and routes responses back only to the granted requester.

---
 rtl/axi_mem_arbiter_pkg.sv | 16 +
 rtl/axi_mem_arbiter_rr_arb2.sv | 26 ++
 rtl/axi_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_arbiter_pkg.sv
// Shared types and AXI width constants for the IFU/LSU memory arbiter.
package axi_mem_arbiter_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_IFU,
    RD_LSU,
    WR_ADDR,
    WR_RESP
  } arb_state_e;

endpackage

// File: rtl/axi_mem_arbiter_rr_arb2.sv
// Two-request round-robin picker: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic upd,
  output logic pick_lsu,
  output logic last_lsu
);

  // LSU wins when alone, or on a tie when the IFU was served last
  always_comb begin
    pick_lsu = req_lsu & (~req_ifu | ~last_lsu);
  end

  // Remember who was granted, updated only when a grant is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu <= 1'b0;
    end else if (upd) begin
      last_lsu <= pick_lsu;
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI master between IFU (read) and LSU (read/write), one
// outstanding transaction at a time, round-robin between the two.
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU read channels
  input  logic [ADDR_W-1:0]   ifu_AR_ADDR,
  input  logic                ifu_AR_VALID,
  output logic                ifu_AR_READY,
  output logic [DATA_W-1:0]   ifu_R_DATA,
  output logic                ifu_R_VALID,
  input  logic                ifu_R_READY,
  // LSU write channels
  input  logic [ADDR_W-1:0]   lsu_AW_ADDR,
  input  logic                lsu_AW_VALID,
  output logic                lsu_AW_READY,
  input  logic [DATA_W-1:0]   lsu_W_DATA,
  input  logic [DATA_W/8-1:0] lsu_W_STRB,
  input  logic                lsu_W_VALID,
  output logic                lsu_W_READY,
  output logic                lsu_B_VALID,
  input  logic                lsu_B_READY,
  // LSU read channels
  input  logic [ADDR_W-1:0]   lsu_AR_ADDR,
  input  logic                lsu_AR_VALID,
  output logic                lsu_AR_READY,
  output logic [DATA_W-1:0]   lsu_R_DATA,
  output logic                lsu_R_VALID,
  input  logic                lsu_R_READY,
  // Downstream AXI master
  output logic [ADDR_W-1:0]   axi_AW_ADDR,
  output logic                axi_AW_VALID,
  input  logic                axi_AW_READY,
  output logic [DATA_W-1:0]   axi_W_DATA,
  output logic [DATA_W/8-1:0] axi_W_STRB,
  output logic                axi_W_VALID,
  input  logic                axi_W_READY,
  input  logic                axi_B_VALID,
  output logic                axi_B_READY,
  output logic [ADDR_W-1:0]   axi_AR_ADDR,
  output logic                axi_AR_VALID,
  input  logic                axi_AR_READY,
  input  logic [DATA_W-1:0]   axi_R_DATA,
  input  logic                axi_R_VALID,
  output logic                axi_R_READY,
  output logic                arb_busy
);

  arb_state_e state, state_n;
  logic       ar_done, ar_done_n;
  logic       aw_done, aw_done_n;
  logic       w_done, w_done_n;

  logic       wr_req;
  logic       lsu_req;
  logic       grant_upd;
  logic       pick_lsu;
  logic       last_lsu;

  // Write and read from the LSU share one request; the write takes precedence
  always_comb begin
    wr_req    = lsu_AW_VALID | lsu_W_VALID;
    lsu_req   = wr_req | lsu_AR_VALID;
    grant_upd = (state == IDLE) & (ifu_AR_VALID | lsu_req);
  end

  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_ifu  (ifu_AR_VALID),
    .req_lsu  (lsu_req),
    .upd      (grant_upd),
    .pick_lsu (pick_lsu),
    .last_lsu (last_lsu)
  );

  // State and handshake-done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      ar_done <= ar_done_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next-state logic and channel muxing for the granted requester
  always_comb begin
    state_n      = state;
    ar_done_n    = ar_done;
    aw_done_n    = aw_done;
    w_done_n     = w_done;
    ifu_AR_READY = 1'b0;
    ifu_R_DATA   = '0;
    ifu_R_VALID  = 1'b0;
    lsu_AW_READY = 1'b0;
    lsu_W_READY  = 1'b0;
    lsu_B_VALID  = 1'b0;
    lsu_AR_READY = 1'b0;
    lsu_R_DATA   = '0;
    lsu_R_VALID  = 1'b0;
    axi_AW_ADDR  = '0;
    axi_AW_VALID = 1'b0;
    axi_W_DATA   = '0;
    axi_W_STRB   = '0;
    axi_W_VALID  = 1'b0;
    axi_B_READY  = 1'b0;
    axi_AR_ADDR  = '0;
    axi_AR_VALID = 1'b0;
    axi_R_READY  = 1'b0;
    arb_busy     = (state != IDLE);

    case (state)
      IDLE: begin
        if (ifu_AR_VALID | lsu_req) begin
          if (pick_lsu) state_n = wr_req ? WR_ADDR : RD_LSU;
          else          state_n = RD_IFU;
        end
      end

      RD_IFU: begin
        axi_AR_ADDR  = ifu_AR_ADDR;
        axi_AR_VALID = ifu_AR_VALID & ~ar_done;
        ifu_AR_READY = axi_AR_READY & ~ar_done;
        if (ifu_AR_VALID & axi_AR_READY & ~ar_done) ar_done_n = 1'b1;
        ifu_R_DATA   = axi_R_DATA;
        ifu_R_VALID  = axi_R_VALID;
        axi_R_READY  = ifu_R_READY;
        if (axi_R_VALID & ifu_R_READY) begin
          state_n   = IDLE;
          ar_done_n = 1'b0;
        end
      end

      RD_LSU: begin
        axi_AR_ADDR  = lsu_AR_ADDR;
        axi_AR_VALID = lsu_AR_VALID & ~ar_done;
        lsu_AR_READY = axi_AR_READY & ~ar_done;
        if (lsu_AR_VALID & axi_AR_READY & ~ar_done) ar_done_n = 1'b1;
        lsu_R_DATA   = axi_R_DATA;
        lsu_R_VALID  = axi_R_VALID;
        axi_R_READY  = lsu_R_READY;
        if (axi_R_VALID & lsu_R_READY) begin
          state_n   = IDLE;
          ar_done_n = 1'b0;
        end
      end

      WR_ADDR: begin
        axi_AW_ADDR  = lsu_AW_ADDR;
        axi_AW_VALID = lsu_AW_VALID & ~aw_done;
        lsu_AW_READY = axi_AW_READY & ~aw_done;
        axi_W_DATA   = lsu_W_DATA;
        axi_W_STRB   = lsu_W_STRB;
        axi_W_VALID  = lsu_W_VALID & ~w_done;
        lsu_W_READY  = axi_W_READY & ~w_done;
        if (lsu_AW_VALID & axi_AW_READY & ~aw_done) aw_done_n = 1'b1;
        if (lsu_W_VALID & axi_W_READY & ~w_done)    w_done_n  = 1'b1;
        // Both handshakes may land in the same cycle; flags clear on exit
        if (aw_done_n & w_done_n) begin
          state_n   = WR_RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end

      WR_RESP: begin
        lsu_B_VALID = axi_B_VALID;
        axi_B_READY = lsu_B_READY;
        if (axi_B_VALID & lsu_B_READY) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench: requester drivers, a simple AXI slave, and a monitor
// that compares downstream/upstream traffic against an expected-order queue.
module tb_axi_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0]   ifu_AR_ADDR;
  logic            ifu_AR_VALID, ifu_AR_READY;
  logic [DW-1:0]   ifu_R_DATA;
  logic            ifu_R_VALID, ifu_R_READY;
  logic [AW-1:0]   lsu_AW_ADDR;
  logic            lsu_AW_VALID, lsu_AW_READY;
  logic [DW-1:0]   lsu_W_DATA;
  logic [DW/8-1:0] lsu_W_STRB;
  logic            lsu_W_VALID, lsu_W_READY;
  logic            lsu_B_VALID, lsu_B_READY;
  logic [AW-1:0]   lsu_AR_ADDR;
  logic            lsu_AR_VALID, lsu_AR_READY;
  logic [DW-1:0]   lsu_R_DATA;
  logic            lsu_R_VALID, lsu_R_READY;
  logic [AW-1:0]   axi_AW_ADDR;
  logic            axi_AW_VALID, axi_AW_READY;
  logic [DW-1:0]   axi_W_DATA;
  logic [DW/8-1:0] axi_W_STRB;
  logic            axi_W_VALID, axi_W_READY;
  logic            axi_B_VALID, axi_B_READY;
  logic [AW-1:0]   axi_AR_ADDR;
  logic            axi_AR_VALID, axi_AR_READY;
  logic [DW-1:0]   axi_R_DATA;
  logic            axi_R_VALID, axi_R_READY;
  logic            arb_busy;

  axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_AR_ADDR(ifu_AR_ADDR), .ifu_AR_VALID(ifu_AR_VALID), .ifu_AR_READY(ifu_AR_READY),
    .ifu_R_DATA(ifu_R_DATA), .ifu_R_VALID(ifu_R_VALID), .ifu_R_READY(ifu_R_READY),
    .lsu_AW_ADDR(lsu_AW_ADDR), .lsu_AW_VALID(lsu_AW_VALID), .lsu_AW_READY(lsu_AW_READY),
    .lsu_W_DATA(lsu_W_DATA), .lsu_W_STRB(lsu_W_STRB), .lsu_W_VALID(lsu_W_VALID),
    .lsu_W_READY(lsu_W_READY), .lsu_B_VALID(lsu_B_VALID), .lsu_B_READY(lsu_B_READY),
    .lsu_AR_ADDR(lsu_AR_ADDR), .lsu_AR_VALID(lsu_AR_VALID), .lsu_AR_READY(lsu_AR_READY),
    .lsu_R_DATA(lsu_R_DATA), .lsu_R_VALID(lsu_R_VALID), .lsu_R_READY(lsu_R_READY),
    .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID), .axi_AW_READY(axi_AW_READY),
    .axi_W_DATA(axi_W_DATA), .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID),
    .axi_W_READY(axi_W_READY), .axi_B_VALID(axi_B_VALID), .axi_B_READY(axi_B_READY),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY),
    .arb_busy(arb_busy)
  );

  typedef struct {
    bit          lsu;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ifu_rv_cnt = 0;
  int   aw_n = 0;
  int   w_n = 0;
  logic aw_block = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] slv_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1234;
    return a ^ 64'hDEAD_BEEF_0000_5A5A;
  endfunction

  function automatic exp_t rd_exp(input bit lsu, input logic [63:0] a);
    exp_t e;
    e.lsu = lsu; e.wr = 1'b0; e.addr = a; e.data = slv_data(a); e.strb = '0;
    return e;
  endfunction

  // AXI slave: AR always ready, R two cycles after AR, B one cycle after AW+W
  initial begin
    logic hs_ar, hs_r, hs_aw, hs_w, hs_b, got_aw, got_w;
    logic [63:0] ar_a, r_addr;
    int r_cnt;
    axi_AR_READY = 1'b1; axi_W_READY = 1'b1; axi_AW_READY = 1'b1;
    axi_R_VALID = 1'b0; axi_R_DATA = '0; axi_B_VALID = 1'b0;
    got_aw = 1'b0; got_w = 1'b0; r_cnt = 0; r_addr = '0;
    forever begin
      @(negedge clk);
      hs_ar = axi_AR_VALID && axi_AR_READY; ar_a = axi_AR_ADDR;
      hs_r  = axi_R_VALID && axi_R_READY;
      hs_aw = axi_AW_VALID && axi_AW_READY;
      hs_w  = axi_W_VALID && axi_W_READY;
      hs_b  = axi_B_VALID && axi_B_READY;
      @(posedge clk); #1;
      axi_AW_READY = !aw_block;
      if (!rst_n) begin
        axi_R_VALID = 1'b0; axi_B_VALID = 1'b0; got_aw = 1'b0; got_w = 1'b0; r_cnt = 0;
      end else begin
        if (hs_r) axi_R_VALID = 1'b0;
        if (r_cnt > 0) begin
          r_cnt--;
          if (r_cnt == 0) begin axi_R_VALID = 1'b1; axi_R_DATA = slv_data(r_addr); end
        end
        if (hs_ar) begin r_addr = ar_a; r_cnt = 2; end
        if (hs_b) axi_B_VALID = 1'b0;
        if (got_aw && got_w) begin axi_B_VALID = 1'b1; got_aw = 1'b0; got_w = 1'b0; end
        if (hs_aw) got_aw = 1'b1;
        if (hs_w)  got_w = 1'b1;
      end
    end
  end

  // Monitor: every handshake is matched against the front of the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifu_R_VALID) ifu_rv_cnt++;
        if (q.size() > 0 && q[0].wr) check("ifu_rdy_in_wr", ifu_AR_READY, 1'b0);
        if (axi_AR_VALID && axi_AR_READY) begin
          if (q.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
          else begin
            check("ar_kind", q[0].wr, 1'b0);
            check("ar_addr", axi_AR_ADDR, q[0].addr);
            check("ar_route", {lsu_AR_READY, ifu_AR_READY}, q[0].lsu ? 2'b10 : 2'b01);
          end
        end
        if (axi_AW_VALID && axi_AW_READY) begin
          aw_n++;
          if (q.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
          else check("aw_addr", axi_AW_ADDR, q[0].addr);
        end
        if (axi_W_VALID && axi_W_READY) begin
          w_n++;
          if (q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
          else begin
            check("w_data", axi_W_DATA, q[0].data);
            check("w_strb", axi_W_STRB, q[0].strb);
          end
        end
        if (lsu_B_VALID && lsu_B_READY) begin
          if (q.size() == 0) check("b_unexpected", 1'b1, 1'b0);
          else begin
            check("b_kind", q[0].wr, 1'b1);
            check("b_aw_once", aw_n, 1);
            check("b_w_once", w_n, 1);
            void'(q.pop_front());
          end
          aw_n = 0; w_n = 0;
        end
        if (ifu_R_VALID && ifu_R_READY) begin
          check("ifu_r_lsu_quiet", lsu_R_VALID, 1'b0);
          if (q.size() == 0) check("ifu_r_unexpected", 1'b1, 1'b0);
          else begin
            check("ifu_r_src", {q[0].wr, q[0].lsu}, 2'b00);
            check("ifu_r_data", ifu_R_DATA, q[0].data);
            void'(q.pop_front());
          end
        end
        if (lsu_R_VALID && lsu_R_READY) begin
          check("lsu_r_ifu_quiet", ifu_R_VALID, 1'b0);
          if (q.size() == 0) check("lsu_r_unexpected", 1'b1, 1'b0);
          else begin
            check("lsu_r_src", {q[0].wr, q[0].lsu}, 2'b01);
            check("lsu_r_data", lsu_R_DATA, q[0].data);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic ifu_req(input logic [63:0] a);
    @(posedge clk); #1;
    ifu_AR_ADDR = a; ifu_AR_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifu_AR_READY) begin
        @(posedge clk); #1;
        ifu_AR_VALID = 1'b0; ifu_AR_ADDR = '0;
        return;
      end
    end
    check("ifu_ar_timeout", 1'b1, 1'b0);
    ifu_AR_VALID = 1'b0;
  endtask

  task automatic lsu_rd(input logic [63:0] a);
    @(posedge clk); #1;
    lsu_AR_ADDR = a; lsu_AR_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lsu_AR_READY) begin
        @(posedge clk); #1;
        lsu_AR_VALID = 1'b0; lsu_AR_ADDR = '0;
        return;
      end
    end
    check("lsu_ar_timeout", 1'b1, 1'b0);
    lsu_AR_VALID = 1'b0;
  endtask

  task automatic lsu_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic aw_h, w_h;
    @(posedge clk); #1;
    lsu_AW_ADDR = a; lsu_W_DATA = d; lsu_W_STRB = s;
    lsu_AW_VALID = 1'b1; lsu_W_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      aw_h = lsu_AW_VALID && lsu_AW_READY;
      w_h  = lsu_W_VALID && lsu_W_READY;
      @(posedge clk); #1;
      if (aw_h) lsu_AW_VALID = 1'b0;
      if (w_h)  lsu_W_VALID = 1'b0;
      if (!lsu_AW_VALID && !lsu_W_VALID) return;
    end
    check("lsu_wr_timeout", 1'b1, 1'b0);
    lsu_AW_VALID = 1'b0; lsu_W_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !arb_busy) return;
    end
    check(tag, 1'b1, 1'b0);
    q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vr"}, {ifu_AR_READY, ifu_R_VALID, lsu_AW_READY, lsu_W_READY, lsu_B_VALID,
                         lsu_AR_READY, lsu_R_VALID, axi_AW_VALID, axi_W_VALID, axi_B_READY,
                         axi_AR_VALID, axi_R_READY, arb_busy}, 13'b0);
    check({tag, "_data"}, axi_AR_ADDR | axi_AW_ADDR | axi_W_DATA | ifu_R_DATA | lsu_R_DATA
                          | {56'b0, axi_W_STRB}, 64'h0);
  endtask

  initial begin
    exp_t e;
    ifu_AR_ADDR = '0; ifu_AR_VALID = 1'b0; ifu_R_READY = 1'b1;
    lsu_AW_ADDR = '0; lsu_AW_VALID = 1'b0; lsu_W_DATA = '0; lsu_W_STRB = '0;
    lsu_W_VALID = 1'b0; lsu_B_READY = 1'b1;
    lsu_AR_ADDR = '0; lsu_AR_VALID = 1'b0; lsu_R_READY = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Simultaneous reads after reset: LSU first, then IFU
    q.push_back(rd_exp(1'b1, 64'h0000_1000));
    q.push_back(rd_exp(1'b0, 64'h0000_2000));
    fork
      ifu_req(64'h0000_2000);
      lsu_rd(64'h0000_1000);
    join
    wait_idle("pair1_timeout");

    // Lone IFU read with grant latency check
    ifu_rv_cnt = 0;
    q.push_back(rd_exp(1'b0, 64'h8000_0000));
    fork
      ifu_req(64'h8000_0000);
      begin
        @(posedge clk);
        @(negedge clk);
        check("ifu_ar_n0", axi_AR_VALID, 1'b0);
        check("ifu_rdy_idle", ifu_AR_READY, 1'b0);
        @(negedge clk);
        check("ifu_ar_n1", axi_AR_VALID, 1'b1);
        check("busy_rd", arb_busy, 1'b1);
      end
    join
    wait_idle("ifu_alone_timeout");
    check("ifu_rv_cycles", ifu_rv_cnt, 1);

    // LSU write with W accepted two cycles before AW
    aw_block = 1'b1;
    e.lsu = 1'b1; e.wr = 1'b1; e.addr = 64'h0000_3000; e.data = 64'hCAFE_F00D_1122_3344; e.strb = 8'h0F;
    q.push_back(e);
    fork
      lsu_wr(64'h0000_3000, 64'hCAFE_F00D_1122_3344, 8'h0F);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (axi_W_VALID && axi_W_READY) seen = 1'b1;
        end
        check("w_seen", seen, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        aw_block = 1'b0;
        @(negedge clk);
        check("w_valid_dropped", axi_W_VALID, 1'b0);
      end
    join
    wait_idle("wr_timeout");

    // Second simultaneous pair: LSU was served last, so IFU first
    q.push_back(rd_exp(1'b0, 64'h0000_4000));
    q.push_back(rd_exp(1'b1, 64'h0000_5000));
    fork
      ifu_req(64'h0000_4000);
      lsu_rd(64'h0000_5000);
    join
    wait_idle("pair2_timeout");

    // IFU request arriving during an LSU write waits for B
    e.lsu = 1'b1; e.wr = 1'b1; e.addr = 64'h0000_6000; e.data = 64'h0102_0304_0506_0708; e.strb = 8'hFF;
    q.push_back(e);
    q.push_back(rd_exp(1'b0, 64'h0000_7000));
    fork
      lsu_wr(64'h0000_6000, 64'h0102_0304_0506_0708, 8'hFF);
      begin
        repeat (2) @(posedge clk);
        ifu_req(64'h0000_7000);
      end
    join
    wait_idle("wr_ifu_timeout");

    // IFU holds R_READY low for three cycles
    ifu_R_READY = 1'b0;
    q.push_back(rd_exp(1'b0, 64'h0000_9000));
    fork
      ifu_req(64'h0000_9000);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (ifu_R_VALID) seen = 1'b1;
        end
        check("stall_rv_seen", seen, 1'b1);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_rready", axi_R_READY, 1'b0);
          check("stall_data", ifu_R_DATA, slv_data(64'h0000_9000));
          check("stall_busy", arb_busy, 1'b1);
        end
        @(posedge clk); #1;
        ifu_R_READY = 1'b1;
      end
    join
    wait_idle("stall_timeout");

    // Reset while RD_LSU waits for R, then a fresh IFU read
    q.push_back(rd_exp(1'b1, 64'h0000_A000));
    lsu_rd(64'h0000_A000);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(rd_exp(1'b0, 64'h0000_B000));
    ifu_req(64'h0000_B000);
    wait_idle("post_rst_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
